// File: rtl/score_display_scan_if.sv
// Signal bundle between the score BCD stage / board pins and the scan driver.
interface score_display_scan_if;
    logic [3:0] units_place;
    logic [3:0] tens_place;
    logic [3:0] hundreds_place;
    logic [3:0] thousands_place;
    logic       lz_blank_en;
    logic       display_en;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    // Source side: supplies digits and controls, observes the pins.
    modport master (
        output units_place, tens_place, hundreds_place, thousands_place,
        output lz_blank_en, display_en,
        input  an, seg, dp, frame_tick
    );

    // Scan driver side.
    modport slave (
        input  units_place, tens_place, hundreds_place, thousands_place,
        input  lz_blank_en, display_en,
        output an, seg, dp, frame_tick
    );
endinterface

// File: rtl/score_display_scan.sv
// 4-digit multiplexed 7-segment scan driver with per-slot dead time,
// per-frame digit snapshot and leading-zero blanking.
module score_display_scan #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    score_display_scan_if.slave  bus
);
    localparam int         CW   = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
    localparam logic       POL  = (ACTIVE_LOW != 0);

    typedef enum logic {BLANK, DRIVE} phase_t;
    localparam phase_t PH0 = (BLANK_CYCLES > 0) ? BLANK : DRIVE;

    logic [CW-1:0]   slot_cnt, slot_nxt;
    logic [1:0]      digit_idx, digit_nxt;
    logic [3:0][3:0] snapshot, cur;
    phase_t          state, state_nxt;
    logic            frame_start;
    logic [3:0]      d;
    logic            blanked;
    logic [3:0]      an_on;
    logic [6:0]      seg_on;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'b0111111;
            4'd1:    decode = 7'b0000110;
            4'd2:    decode = 7'b1011011;
            4'd3:    decode = 7'b1001111;
            4'd4:    decode = 7'b1100110;
            4'd5:    decode = 7'b1101101;
            4'd6:    decode = 7'b1111101;
            4'd7:    decode = 7'b0000111;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1101111;
            default: decode = 7'b1000000;
        endcase
    endfunction

    // Slot/digit counter successors; digit_idx wraps 3->0 naturally.
    always_comb begin
        slot_nxt  = (slot_cnt == LAST) ? '0 : slot_cnt + 1'b1;
        digit_nxt = (slot_cnt == LAST) ? digit_idx + 2'd1 : digit_idx;
    end

    // At frame start the live inputs are used directly so the cycle that
    // loads the snapshot already shows the new digits.
    always_comb begin
        frame_start = (slot_cnt == '0) && (digit_idx == 2'd0);
        cur = frame_start ? {bus.thousands_place, bus.hundreds_place,
                             bus.tens_place, bus.units_place} : snapshot;
        d = cur[digit_idx];
        blanked = 1'b0;
        if (bus.lz_blank_en) begin
            case (digit_idx)
                2'd3:    blanked = (cur[3] == 4'd0);
                2'd2:    blanked = (cur[3] == 4'd0) && (cur[2] == 4'd0);
                2'd1:    blanked = (cur[3] == 4'd0) && (cur[2] == 4'd0) && (cur[1] == 4'd0);
                default: blanked = 1'b0;
            endcase
        end
    end

    // Counters and per-frame snapshot.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt  <= '0;
            digit_idx <= 2'd0;
            snapshot  <= '0;
        end else begin
            slot_cnt  <= slot_nxt;
            digit_idx <= digit_nxt;
            if (frame_start) snapshot <= cur;
        end
    end

    // Phase register: tracks which half of the slot slot_cnt is in.
    always_ff @(posedge clk) begin
        if (reset) state <= PH0;
        else       state <= state_nxt;
    end

    // Next phase follows the next slot count.
    always_comb begin
        state_nxt = (32'(slot_nxt) < BLANK_CYCLES) ? BLANK : DRIVE;
    end

    // Active-high pin values for the current slot position.
    always_comb begin
        an_on  = 4'b0000;
        seg_on = 7'b0000000;
        if (state == DRIVE && bus.display_en && !blanked) begin
            an_on[digit_idx] = 1'b1;
            seg_on           = decode(d);
        end
    end

    // Registered pins with polarity applied; reset forces everything off.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.an         <= {4{POL}};
            bus.seg        <= {7{POL}};
            bus.dp         <= POL;
            bus.frame_tick <= 1'b0;
        end else begin
            bus.an         <= an_on ^ {4{POL}};
            bus.seg        <= seg_on ^ {7{POL}};
            bus.dp         <= POL;
            bus.frame_tick <= frame_start;
        end
    end
endmodule

// File: tb/tb_score_display_scan.sv
// Scoreboard bench: stimulus pushes expected pin values per cycle, a monitor
// pops and compares one cycle later.
module tb_score_display_scan;
    localparam int RD = 8;
    localparam int BC = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    score_display_scan_if sif();

    score_display_scan #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .ACTIVE_LOW(1)) dut (
        .clk(clk), .reset(reset), .bus(sif)
    );

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ft;
        logic       chk_seg;
        string      tag;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;
    string tag = "reset";

    // Bench model state.
    int m_slot = 0;
    int m_dig = 0;
    logic [3:0][3:0] m_snap = '0;

    // Active-high gfedcba patterns.
    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0: seg_of = 7'b0111111;  4'd1: seg_of = 7'b0000110;
            4'd2: seg_of = 7'b1011011;  4'd3: seg_of = 7'b1001111;
            4'd4: seg_of = 7'b1100110;  4'd5: seg_of = 7'b1101101;
            4'd6: seg_of = 7'b1111101;  4'd7: seg_of = 7'b0000111;
            4'd8: seg_of = 7'b1111111;  4'd9: seg_of = 7'b1101111;
            default: seg_of = 7'b1000000;
        endcase
    endfunction

    task automatic step();
        exp_t e;
        logic fs, blk;
        logic [3:0] d, oh;
        e.tag = tag; e.dp = 1'b1; e.chk_seg = 1'b1;
        e.an = 4'b1111; e.seg = 7'b1111111; e.ft = 1'b0;
        if (reset) begin
            m_slot = 0; m_dig = 0; m_snap = '0;
        end else begin
            fs = (m_slot == 0) && (m_dig == 0);
            if (fs) m_snap = {sif.thousands_place, sif.hundreds_place, sif.tens_place, sif.units_place};
            e.ft = fs;
            d = m_snap[m_dig];
            blk = sif.lz_blank_en && (
                  (m_dig == 3 && m_snap[3] == 0) ||
                  (m_dig == 2 && m_snap[3] == 0 && m_snap[2] == 0) ||
                  (m_dig == 1 && m_snap[3] == 0 && m_snap[2] == 0 && m_snap[1] == 0));
            if (!sif.display_en) e.chk_seg = 1'b0;
            else if (m_slot < BC) ;
            else if (blk) e.chk_seg = 1'b0;
            else begin
                oh = 4'b0001; oh = oh << m_dig;
                e.an = ~oh;
                e.seg = ~seg_of(d);
            end
            if (m_slot == RD - 1) begin m_slot = 0; m_dig = (m_dig + 1) % 4; end
            else m_slot = m_slot + 1;
        end
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_digits(input logic [3:0] th, hu, te, un);
        sif.thousands_place = th; sif.hundreds_place = hu;
        sif.tens_place = te; sif.units_place = un;
    endtask

    // Monitor: compare one popped expectation per cycle, just after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            tests++;
            if (sif.an !== e.an) begin
                fails++;
                $display("FAIL %s an: got %b want %b", e.tag, sif.an, e.an);
            end
            if (e.chk_seg) begin
                tests++;
                if (sif.seg !== e.seg) begin
                    fails++;
                    $display("FAIL %s seg: got %b want %b", e.tag, sif.seg, e.seg);
                end
            end
            tests++;
            if (sif.dp !== e.dp) begin
                fails++;
                $display("FAIL %s dp: got %b want %b", e.tag, sif.dp, e.dp);
            end
            tests++;
            if (sif.frame_tick !== e.ft) begin
                fails++;
                $display("FAIL %s frame_tick: got %b want %b", e.tag, sif.frame_tick, e.ft);
            end
        end
    end

    initial begin
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        sif.lz_blank_en = 1'b1;
        sif.display_en = 1'b1;
        @(negedge clk);
        reset = 1'b1; tag = "reset";
        run(3);
        reset = 1'b0;

        tag = "t1_1234";   run(4 * RD);
        tag = "t2_zero";   set_digits(4'd0, 4'd0, 4'd0, 4'd0); run(4 * RD);
        tag = "t3_lz_on";  set_digits(4'd0, 4'd5, 4'd0, 4'd7); run(4 * RD);
        tag = "t3_lz_off"; sif.lz_blank_en = 1'b0; run(4 * RD);
        sif.lz_blank_en = 1'b1;

        tag = "t4_tear";   set_digits(4'd1, 4'd2, 4'd3, 4'd4); run(10);
        set_digits(4'd9, 4'd8, 4'd7, 4'd6); run(4 * RD - 10);
        tag = "t4_9876";   run(4 * RD);

        tag = "t5_dash";   set_digits(4'd1, 4'd2, 4'd3, 4'hC); run(4 * RD);

        tag = "t6_den";    set_digits(4'd1, 4'd2, 4'd3, 4'd4); run(12);
        sif.display_en = 1'b0; run(3);
        sif.display_en = 1'b1; run(4 * RD - 15);

        tag = "t6_rst";    run(12);
        reset = 1'b1; run(2);
        reset = 1'b0; tag = "t6_post"; run(4 * RD + 4);

        @(negedge clk);
        @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
